// File: rtl/imem_load_sequencer_if.sv
// Program-word stream between the loader (master) and imem_load_sequencer (slave).
// DATA_W must match the DATA_W of the sequencer it is connected to.
interface imem_load_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              WrValid;
    logic [DATA_W-1:0] WrData;
    logic              WrReady;

    modport master (output WrValid, output WrData, input WrReady);
    modport slave  (input WrValid, input WrData, output WrReady);
endinterface

// File: rtl/imem_load_sequencer.sv
// Instruction-memory load sequencer: loads a program over a valid/ready stream,
// pads the rest of the 16-word memory with NOP_WORD, then releases the core and
// serves range-checked PC fetches.
// Optional feature macro: IMM_PATCH_EN adds port Input[15:0], whose value replaces
// the low 16 bits of the word written to address 0.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for Start, core held
// LOAD  | accepting program words, writing at cnt
// FILL  | writing NOP_WORD to the unloaded tail
// RUN   | core released, memory port serves PcAddr
module imem_load_sequencer #(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [ADDR_W:0]       WrCount,
    imem_load_sequencer_if.slave  wr,
    input  logic [31:0]           PcAddr,
    output logic                  MemWe,
    output logic [ADDR_W-1:0]     MemAddr,
    output logic [DATA_W-1:0]     MemWData,
    input  logic [DATA_W-1:0]     MemRData,
    output logic [DATA_W-1:0]     InstrOut,
    output logic                  CpuRun,
    output logic                  Busy,
    output logic                  AddrErr
`ifdef IMM_PATCH_EN
    ,
    input  logic [15:0]           Input
`endif
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FILL = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W:0]   cnt, cnt_nxt;
    logic [ADDR_W:0]   len, len_nxt;
    logic              addr_err_nxt;
    logic              start_acc;
    logic              pc_oob;
    logic [DATA_W-1:0] load_data;

    // State, counters and the sticky fetch error register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            len     <= '0;
            AddrErr <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            len     <= len_nxt;
            AddrErr <= addr_err_nxt;
        end
    end

    // Word written during LOAD; optionally patch the first word's immediate field.
    always_comb begin
        load_data = wr.WrData;
`ifdef IMM_PATCH_EN
        if (cnt == '0) begin
            load_data = {wr.WrData[DATA_W-1:16], Input};
        end
`endif
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        len_nxt      = len;
        addr_err_nxt = AddrErr;
        start_acc    = 1'b0;
        wr.WrReady   = 1'b0;
        MemWe        = 1'b0;
        MemAddr      = '0;
        MemWData     = NOP_WORD;
        InstrOut     = NOP_WORD;
        CpuRun       = 1'b0;
        Busy         = 1'b0;
        pc_oob       = (PcAddr >= 32'(DEPTH));

        case (state)
            S_IDLE: begin
                start_acc = Start;
            end
            S_LOAD: begin
                Busy       = 1'b1;
                wr.WrReady = 1'b1;
                MemAddr    = cnt[ADDR_W-1:0];
                if (wr.WrValid) begin
                    MemWe    = 1'b1;
                    MemWData = load_data;
                    cnt_nxt  = cnt + ONE_C;
                    if (cnt == len - ONE_C) begin
                        state_nxt = (len < DEPTH_C) ? S_FILL : S_RUN;
                    end
                end
            end
            S_FILL: begin
                Busy    = 1'b1;
                MemWe   = 1'b1;
                MemAddr = cnt[ADDR_W-1:0];
                cnt_nxt = cnt + ONE_C;
                if (cnt == LAST_C) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                CpuRun  = 1'b1;
                MemAddr = PcAddr[ADDR_W-1:0];
                if (pc_oob) begin
                    addr_err_nxt = 1'b1;
                end else begin
                    InstrOut = MemRData;
                end
                start_acc = Start;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // A new load clears the old fetch error even if this cycle's fetch was out of range.
        if (start_acc) begin
            len_nxt      = (WrCount > DEPTH_C) ? DEPTH_C : WrCount;
            cnt_nxt      = '0;
            addr_err_nxt = 1'b0;
            state_nxt    = (WrCount != '0) ? S_LOAD : S_FILL;
        end
    end

endmodule

// File: tb/tb_imem_load_sequencer.sv
// Bench for imem_load_sequencer: memory model plus write scoreboard, load sequences
// with bounded waits, and table-driven fetch vectors in RUN.
module tb_imem_load_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [4:0]  WrCount;
    logic [31:0] PcAddr;
    logic        MemWe;
    logic [3:0]  MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic [31:0] InstrOut;
    logic        CpuRun;
    logic        Busy;
    logic        AddrErr;
`ifdef IMM_PATCH_EN
    logic [15:0] Input;
`endif

    imem_load_sequencer_if #(.DATA_W(32)) wr_if ();

    imem_load_sequencer #(.ADDR_W(4), .DATA_W(32), .NOP_WORD(32'h0)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .WrCount  (WrCount),
        .wr       (wr_if),
        .PcAddr   (PcAddr),
        .MemWe    (MemWe),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemRData (MemRData),
        .InstrOut (InstrOut),
        .CpuRun   (CpuRun),
        .Busy     (Busy),
        .AddrErr  (AddrErr)
`ifdef IMM_PATCH_EN
        ,
        .Input    (Input)
`endif
    );

    always #5 Clk = ~Clk;

    logic [31:0] mem [16];
    always @(posedge Clk) if (MemWe) mem[MemAddr] <= MemWData;
    assign MemRData = mem[MemAddr];

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } fvec_t;
    fvec_t ftab[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write scoreboard: every memory write must match the next expected {addr,data}.
    always @(negedge Clk) begin
        if (Reset === 1'b0 && MemWe === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %0d data %h, none expected", MemAddr, MemWData);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {28'h0, MemAddr}, {28'h0, e.addr});
                check("wr_data", MemWData, e.data);
            end
        end
    end

    function automatic logic [31:0] wexp(input logic [31:0] base, input int i);
        logic [31:0] w;
        w = base + 32'(i);
`ifdef IMM_PATCH_EN
        if (i == 0) w = {w[31:16], 16'h000A};
`endif
        return w;
    endfunction

    task automatic push_seq(input int count, input logic [31:0] base);
        int len;
        len = (count > 16) ? 16 : count;
        for (int i = 0; i < len; i++) exp_q.push_back({4'(i), wexp(base, i)});
        for (int i = len; i < 16; i++) exp_q.push_back({4'(i), 32'h0});
    endtask

    task automatic load_seq(input int count, input logic [31:0] base, input logic [15:0] vmask,
                            input int start_at, input int exp_cyc, input int exp_rdy,
                            input string tag);
        int n;
        int idx;
        int rdy;
        bit done;
        n = 0; idx = 0; rdy = 0; done = 1'b0;
        push_seq(count, base);
        @(posedge Clk); #1;
        Start   = 1'b1;
        WrCount = 5'(count);
        @(posedge Clk); #1;
        Start = 1'b0;
        while (!done && n < 80) begin
            wr_if.WrValid = vmask[n % 16];
            wr_if.WrData  = base + 32'(idx);
            Start         = (n == start_at);
            @(negedge Clk);
            if (n == 0) begin
                check({tag, "_busy"}, {31'h0, Busy}, 32'h1);
                check({tag, "_err_clear"}, {31'h0, AddrErr}, 32'h0);
            end
            if (CpuRun) begin
                done = 1'b1;
            end else begin
                if (wr_if.WrReady) rdy++;
                if (wr_if.WrValid && wr_if.WrReady) idx++;
                @(posedge Clk); #1;
                n++;
            end
        end
        Start = 1'b0;
        check({tag, "_run_cycles"}, 32'(n), 32'(exp_cyc));
        check({tag, "_ready_cycles"}, 32'(rdy), 32'(exp_rdy));
        check({tag, "_writes_left"}, 32'(exp_q.size()), 32'h0);
    endtask

    task automatic apply_fetch(input string tag);
        @(posedge Clk); #1;
        for (int i = 0; i < ftab.size(); i++) begin
            PcAddr = ftab[i].pc;
            @(negedge Clk);
            check({tag, "_instr"}, InstrOut, ftab[i].instr);
            check({tag, "_wrready"}, {31'h0, wr_if.WrReady}, 32'h0);
            @(posedge Clk); #1;
            check({tag, "_addrerr"}, {31'h0, AddrErr}, {31'h0, ftab[i].err});
        end
        ftab.delete();
        PcAddr        = 32'h0;
        wr_if.WrValid = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; WrCount = '0; PcAddr = '0;
        wr_if.WrValid = 1'b0; wr_if.WrData = '0;
`ifdef IMM_PATCH_EN
        Input = 16'h000A;
`endif
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_wrready", {31'h0, wr_if.WrReady}, 32'h0);
        check("rst_memwe",   {31'h0, MemWe}, 32'h0);
        check("rst_cpurun",  {31'h0, CpuRun}, 32'h0);
        check("rst_busy",    {31'h0, Busy}, 32'h0);
        check("rst_addrerr", {31'h0, AddrErr}, 32'h0);
        check("rst_instr",   InstrOut, 32'h0);
        check("rst_memaddr", {28'h0, MemAddr}, 32'h0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        // Three words then 13 fill writes.
        load_seq(3, 32'hA000_0000, 16'hFFFF, -1, 16, 3, "t1");
        ftab.push_back('{32'd0,  wexp(32'hA000_0000, 0), 1'b0});
        ftab.push_back('{32'd2,  wexp(32'hA000_0000, 2), 1'b0});
        ftab.push_back('{32'd3,  32'h0, 1'b0});
        ftab.push_back('{32'd15, 32'h0, 1'b0});
        apply_fetch("f1");

        // Count clipped from 20 to 16; extra offered words must not be written.
        load_seq(20, 32'hC0DE_0000, 16'hFFFF, -1, 16, 16, "t3clip");
        ftab.push_back('{32'd5,        32'hC0DE_0005, 1'b0});
        ftab.push_back('{32'd16,       32'h0,         1'b1});
        ftab.push_back('{32'd2,        32'hC0DE_0002, 1'b1});
        ftab.push_back('{32'd15,       32'hC0DE_000F, 1'b1});
        ftab.push_back('{32'hFFFF_FFFF, 32'h0,        1'b1});
        apply_fetch("f3");

        // Restart from RUN with valid gaps 1,0,0,1; start clears AddrErr.
        load_seq(2, 32'hD000_0000, 16'h0009, -1, 18, 4, "t2");
        ftab.push_back('{32'd1, wexp(32'hD000_0000, 1), 1'b0});
        ftab.push_back('{32'd0, wexp(32'hD000_0000, 0), 1'b0});
        ftab.push_back('{32'd7, 32'h0, 1'b0});
        apply_fetch("f2");

        // Zero words: pure fill; a Start pulse in FILL must be ignored.
        load_seq(0, 32'hBAD0_0000, 16'hFFFF, 5, 16, 0, "t3zero");
        ftab.push_back('{32'd0, 32'h0, 1'b0});
        apply_fetch("f3z");

        // Exactly 16 words, no fill; first word carries the immediate patch when enabled.
        load_seq(16, 32'h0401_0000, 16'hFFFF, -1, 16, 16, "t3full");
        ftab.push_back('{32'd0,  wexp(32'h0401_0000, 0), 1'b0});
        ftab.push_back('{32'd1,  32'h0401_0001, 1'b0});
        ftab.push_back('{32'd15, 32'h0401_000F, 1'b0});
        apply_fetch("f6");

        // Reset on the second LOAD word returns to IDLE with the core held.
        exp_q.push_back({4'd0, wexp(32'hE000_0000, 0)});
        @(posedge Clk); #1;
        Start = 1'b1; WrCount = 5'd4;
        wr_if.WrValid = 1'b1; wr_if.WrData = 32'hE000_0000;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(posedge Clk); #1;
        wr_if.WrData = 32'hE000_0001;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("t5_cpurun",  {31'h0, CpuRun}, 32'h0);
        check("t5_wrready", {31'h0, wr_if.WrReady}, 32'h0);
        check("t5_busy",    {31'h0, Busy}, 32'h0);
        check("t5_instr",   InstrOut, 32'h0);
        check("t5_left",    32'(exp_q.size()), 32'h0);
        @(posedge Clk); #1;
        wr_if.WrValid = 1'b0;
        @(negedge Clk);
        check("t5_idle_hold", {31'h0, CpuRun}, 32'h0);

        // Start and Reset together: Reset wins.
        @(posedge Clk); #1;
        Start = 1'b1; Reset = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0; Reset = 1'b0;
        @(negedge Clk);
        check("t5_rst_wins_busy", {31'h0, Busy}, 32'h0);
        @(posedge Clk); #1;
        @(negedge Clk);
        check("t5_rst_wins_idle", {31'h0, Busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
